// File: rtl/efuse_prog_seq.sv
// efuse_prog_seq
//   Sequencer between a word-level command port and one eFuse array macro.
//   A word write is split into one program pulse per set bit, LSB first,
//   with fixed setup, pulse-width and hold timing. A word read raises a
//   sense strobe of fixed width and captures the macro data on its last cycle.
//
// Ports
//   clock, resetb       system clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_write           1 = program word, 0 = read word
//   cmd_addr/cmd_wdata  word address, bits to blow (1 = program)
//   prog_enable         global program arm, sampled at accept and per scan
//   rsp_valid           one-cycle response pulse, no backpressure
//   rsp_rdata/rsp_err   read data (held until next read), error flag
//   busy                high whenever not idle
//   fuse_addr/fuse_bit  macro word address / bit select
//   fuse_prog           program pulse
//   fuse_sense          sense strobe
//   fuse_rdata          macro read data
module efuse_prog_seq #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned BIT_W        = $clog2(DATA_W),
  parameter int unsigned SETUP_CYCLES = 4,
  parameter int unsigned PROG_CYCLES  = 200,
  parameter int unsigned SENSE_CYCLES = 4
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              prog_enable,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] fuse_addr,
  output logic [BIT_W-1:0]  fuse_bit,
  output logic              fuse_prog,
  output logic              fuse_sense,
  input  logic [DATA_W-1:0] fuse_rdata
);

  // The shared down-counter must be able to hold the longest phase.
  localparam int unsigned MAX_SP  = (SETUP_CYCLES > PROG_CYCLES) ? SETUP_CYCLES : PROG_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_SP > SENSE_CYCLES) ? MAX_SP : SENSE_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC + 1) : 1;

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PROG_LOAD  = CNT_W'(PROG_CYCLES - 1);
  localparam logic [CNT_W-1:0] SENSE_LOAD = CNT_W'(SENSE_CYCLES - 1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_SENSE,
    S_WR_SCAN,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_RESP
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] wdata_q;
  logic [BIT_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;

  // fuse_prog/fuse_sense are plain flops with asynchronous clear, so both
  // drop the instant resetb goes low without waiting for a clock edge.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state      <= S_IDLE;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      fuse_addr  <= '0;
      fuse_bit   <= '0;
      fuse_prog  <= 1'b0;
      fuse_sense <= 1'b0;
      wdata_q    <= '0;
      idx        <= '0;
      cnt        <= '0;
    end else begin
      rsp_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            fuse_addr <= cmd_addr;
            wdata_q   <= cmd_wdata;
            idx       <= '0;
            if (!cmd_write) begin
              state      <= S_RD_SENSE;
              fuse_sense <= 1'b1;
              cnt        <= SENSE_LOAD;
            end else if (!prog_enable) begin
              // Disarmed write: refuse without touching the macro.
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state <= S_WR_SCAN;
            end
          end
        end

        S_RD_SENSE: begin
          if (cnt == '0) begin
            // Last sense cycle: capture macro data, close the strobe.
            fuse_sense <= 1'b0;
            rsp_rdata  <= fuse_rdata;
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_WR_SCAN: begin
          if (!prog_enable) begin
            // Arm withdrawn: abandon the remaining bits.
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else if (wdata_q[idx]) begin
            fuse_bit <= idx;
            cnt      <= SETUP_LOAD;
            state    <= S_WR_SETUP;
          end else if (idx == LAST_BIT) begin
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        S_WR_SETUP: begin
          if (cnt == '0) begin
            fuse_prog <= 1'b1;
            cnt       <= PROG_LOAD;
            state     <= S_WR_PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        // prog_enable is deliberately ignored here: a started pulse always
        // runs to full width and is followed by its hold cycle.
        S_WR_PULSE: begin
          if (cnt == '0) begin
            fuse_prog <= 1'b0;
            state     <= S_WR_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_WR_HOLD: begin
          if (idx == LAST_BIT) begin
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_WR_SCAN;
          end
        end

        S_RESP: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end

        default: begin
          fuse_prog  <= 1'b0;
          fuse_sense <= 1'b0;
          cmd_ready  <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
